// File: rtl/seven_seg_pkg.sv
// Shared constants and types for the seven-segment scanner.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package seven_seg_pkg;

    typedef enum logic {
        DRIVE = 1'b0,
        BLANK = 1'b1
    } phase_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

    // Width needed to count up to the largest of three limits, at least 1.
    function automatic int cnt_width(int a, int b, int c);
        int m;
        int w;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        w = $clog2(m);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/hex_to_seven_seg.sv
// Hex nibble to active-low seven-segment pattern.
// Purely combinational, used on the selected digit.
module hex_to_seven_seg
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Table lookup of the glyph for one nibble
    always_comb begin
        seg = SEG_OFF;
        unique case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
        endcase
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Multiplexed common-anode display scanner with per-frame snapshot,
// inter-digit blanking and leading-zero suppression.
module seven_seg_scanner #(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL_CYCLES = 3,
    parameter int BLANK_CYCLES = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    lz_suppress,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_start
);

    import seven_seg_pkg::*;

    localparam int CW = cnt_width(NUM_DIGITS, DWELL_CYCLES, BLANK_CYCLES);
    localparam logic [CW-1:0] DW_LAST  = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] BL_LAST  = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [CW-1:0] IDX_LAST = CW'(NUM_DIGITS - 1);

    phase_t          phase;
    logic [CW-1:0]   idx;
    logic [CW-1:0]   cnt;
    logic            run;

    logic [4*NUM_DIGITS-1:0] snap_val;
    logic [NUM_DIGITS-1:0]   snap_dp;
    logic [NUM_DIGITS-1:0]   snap_en;
    logic                    snap_lz;

    phase_t          nxt_phase;
    logic [CW-1:0]   nxt_idx;
    logic [CW-1:0]   nxt_cnt;
    logic [CW-1:0]   adv_idx;
    logic            frame_edge;

    logic [4*NUM_DIGITS-1:0] f_val;
    logic [NUM_DIGITS-1:0]   f_dp;
    logic [NUM_DIGITS-1:0]   f_en;
    logic                    f_lz;
    logic [NUM_DIGITS-1:0]   sup;
    logic [3:0]              nib;
    logic [6:0]              dec_seg;
    logic                    visible;

    assign adv_idx = (idx == IDX_LAST) ? '0 : idx + 1'b1;

    // Phase/dwell sequencing; the first edge out of reset starts digit 0
    always_comb begin
        nxt_phase = phase;
        nxt_idx   = idx;
        nxt_cnt   = cnt;
        unique case (1'b1)
            !run: begin
                nxt_phase = DRIVE;
                nxt_idx   = '0;
                nxt_cnt   = '0;
            end
            run && phase == DRIVE: begin
                if (cnt == DW_LAST) begin
                    nxt_cnt = '0;
                    if (BLANK_CYCLES == 0) nxt_idx = adv_idx;
                    else nxt_phase = BLANK;
                end else begin
                    nxt_cnt = cnt + 1'b1;
                end
            end
            run && phase == BLANK: begin
                if (cnt == BL_LAST) begin
                    nxt_cnt   = '0;
                    nxt_phase = DRIVE;
                    nxt_idx   = adv_idx;
                end else begin
                    nxt_cnt = cnt + 1'b1;
                end
            end
        endcase
    end

    assign frame_edge = (nxt_phase == DRIVE) && (nxt_idx == '0) && (nxt_cnt == '0);

    // On the frame edge the decode must already see the new snapshot
    assign f_val = frame_edge ? value       : snap_val;
    assign f_dp  = frame_edge ? dp_in       : snap_dp;
    assign f_en  = frame_edge ? digit_en    : snap_en;
    assign f_lz  = frame_edge ? lz_suppress : snap_lz;

    // A digit is a leading zero if it and every digit above it are zero
    always_comb begin
        logic all_zero;
        all_zero = 1'b1;
        sup      = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            all_zero = all_zero & (f_val[4*i +: 4] == 4'h0);
            sup[i]   = f_lz & all_zero & (i != 0);
        end
    end

    assign nib     = f_val[4*nxt_idx +: 4];
    assign visible = (nxt_phase == DRIVE) && f_en[nxt_idx] && !sup[nxt_idx];

    hex_to_seven_seg u_dec (
        .nibble (nib),
        .seg    (dec_seg)
    );

    // Scan state registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            phase <= BLANK;
            idx   <= IDX_LAST;
            cnt   <= '0;
            run   <= 1'b0;
        end else begin
            phase <= nxt_phase;
            idx   <= nxt_idx;
            cnt   <= nxt_cnt;
            run   <= 1'b1;
        end
    end

    // Coherent per-frame capture of the display inputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            snap_val <= '0;
            snap_dp  <= '0;
            snap_en  <= '0;
            snap_lz  <= 1'b0;
        end else if (frame_edge) begin
            snap_val <= value;
            snap_dp  <= dp_in;
            snap_en  <= digit_en;
            snap_lz  <= lz_suppress;
        end
    end

    // Registered display outputs for the upcoming cycle
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            an          <= '1;
            seg         <= SEG_OFF;
            dp          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            frame_start <= frame_edge;
            if (visible) begin
                an  <= ~(NUM_DIGITS'(1) << nxt_idx);
                seg <= dec_seg;
                dp  <= ~f_dp[nxt_idx];
            end else begin
                an  <= '1;
                seg <= SEG_OFF;
                dp  <= 1'b1;
            end
        end
    end

endmodule
